// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with a 2-flop column synchronizer, debounce and ghost rejection.
// Auto-repeat of a held key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8,
   parameter int REPEAT_DELAY = 250,
   parameter int REPEAT_RATE  = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] kc,
   output logic [3:0] kr,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CNT);

   if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("keypad_scanner: SCAN_DIV must be >= 4 and all counts >= 1");
   end

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   state_t          state, state_n;
   logic [3:0]      kc_m, kc_s;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [1:0]      row, row_n;
   logic [CW-1:0]   cnt, cnt_n, cnt_inc;
   logic [CW-1:0]   rel, rel_n, rel_inc;
   logic [3:0]      cand, cand_n;
   logic [3:0]      code_n;
   logic            valid_n, held_n, accept;
   logic            press;
   logic [1:0]      col;
   logic [3:0]      code;

`ifdef KEYPAD_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW = $clog2(RMAX + 1);
   logic [RW-1:0] rep, rep_n, rep_inc, rep_tgt;
   logic          rep_first, rep_first_n, rep_hit;
   assign rep_tgt = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
   assign rep_inc = (rep == rep_tgt) ? rep : rep + 1'b1;
   assign rep_hit = (rep_inc == rep_tgt);
`endif

   assign tick    = (div_cnt == DIV_MAX);
   assign kr      = ~(4'b0001 << row);
   // Exactly one low column is a press; anything else (idle or ghosting) is not.
   assign press   = (kc_s == 4'hE) | (kc_s == 4'hD) | (kc_s == 4'hB) | (kc_s == 4'h7);
   assign col     = {~kc_s[2] | ~kc_s[3], ~kc_s[1] | ~kc_s[3]};
   assign code    = {row, col};
   assign cnt_inc = (cnt == DB_MAX) ? cnt : cnt + 1'b1;
   assign rel_inc = (rel == DB_MAX) ? rel : rel + 1'b1;

   always_comb begin
      state_n = state;
      row_n   = row;
      cnt_n   = cnt;
      rel_n   = rel;
      cand_n  = cand;
      code_n  = key_code;
      held_n  = key_held;
      valid_n = 1'b0;
      accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_n       = rep;
      rep_first_n = rep_first;
`endif
      if (tick) begin
         case (state)
            SCAN: begin
               if (press) begin
                  cand_n  = code;
                  cnt_n   = CW'(1);
                  accept  = (DEBOUNCE_CNT == 1);
                  state_n = DEBOUNCE;
               end else begin
                  row_n = row + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (press && code == cand) begin
                  cnt_n  = cnt_inc;
                  accept = (cnt_inc == DB_MAX);
               end else begin
                  cnt_n   = '0;
                  row_n   = row + 2'd1;
                  state_n = SCAN;
               end
            end
            HELD: begin
               if (press && code == key_code) begin
                  rel_n = '0;
`ifdef KEYPAD_REPEAT_EN
                  rep_n       = rep_hit ? '0 : rep_inc;
                  rep_first_n = rep_hit ? 1'b0 : rep_first;
                  valid_n     = rep_hit;
`endif
               end else begin
                  rel_n = rel_inc;
`ifdef KEYPAD_REPEAT_EN
                  rep_n       = '0;
                  rep_first_n = 1'b1;
`endif
                  if (rel_inc == DB_MAX) begin
                     rel_n   = '0;
                     held_n  = 1'b0;
                     row_n   = row + 2'd1;
                     state_n = SCAN;
                  end
               end
            end
            default: state_n = SCAN;
         endcase
         if (accept) begin
            code_n  = code;
            valid_n = 1'b1;
            held_n  = 1'b1;
            cnt_n   = '0;
            rel_n   = '0;
            state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_n       = '0;
            rep_first_n = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SCAN;
         kc_m      <= '0;
         kc_s      <= '0;
         div_cnt   <= '0;
         row       <= '0;
         cnt       <= '0;
         rel       <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep       <= '0;
         rep_first <= 1'b1;
`endif
      end else begin
         state     <= state_n;
         kc_m      <= kc;
         kc_s      <= kc_m;
         div_cnt   <= tick ? '0 : div_cnt + 1'b1;
         row       <= row_n;
         cnt       <= cnt_n;
         rel       <= rel_n;
         cand      <= cand_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         key_held  <= held_n;
`ifdef KEYPAD_REPEAT_EN
         rep       <= rep_n;
         rep_first <= rep_first_n;
`endif
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, ghost rejection, reset abort and hold behaviour.
module tb_keypad_scanner;
   localparam int SD = 4;
   localparam int DB = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] kc, kr, key_code;
   logic       key_valid, key_held;
   logic       key_on = 1'b0, force_on = 1'b0;
   logic [1:0] key_row = 2'd0, key_col = 2'd0;
   logic [3:0] force_kc = 4'hF;
   int         n_chk = 0, n_err = 0, cyc = 0, n_pulse = 0;
   int         pulse_cyc[$];
   logic [3:0] pulse_code[$];

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
      .clk(clk), .rst_n(rst_n), .kc(kc), .kr(kr),
      .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // A pressed key pulls its column low only while its row is driven.
   always_comb kc = force_on ? force_kc : (key_on && !kr[key_row]) ? ~(4'b0001 << key_col) : 4'hF;

   always @(negedge clk)
      if (key_valid) begin
         n_pulse++;
         pulse_cyc.push_back(cyc);
         pulse_code.push_back(key_code);
      end

   function automatic logic [3:0] rowpat(input int i);
      logic [3:0] p;
      p = 4'b0001 << i;
      return ~p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_row(input logic [3:0] r);
      int i = 0;
      while (kr == r && i < 100) begin step(1); i++; end
      while (kr != r && i < 100) begin step(1); i++; end
      chk("wait_row", kr, r);
   endtask

   task automatic wait_pulse(input string tag);
      int i = 0;
      while (!key_valid && i < 200) begin step(1); i++; end
      chk(tag, key_valid, 1'b1);
   endtask

   initial begin
      int p0, i;
      logic [3:0] prev;
      step(3);
      chk("rst_kr", kr, 4'hE);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_code", key_code, 4'h0);
      chk("rst_held", key_held, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      for (int k = 1; k <= 40; k++) begin
         step(1);
         if (k % 4 == 0) chk("idle_kr", kr, rowpat((k / 4) % 4));
      end
      chk("idle_pulses", n_pulse, 0);

      key_row = 2'd2; key_col = 2'd1; key_on = 1'b1;
      p0 = n_pulse;
      wait_pulse("press_valid");
      chk("press_code", key_code, 4'd9);
      chk("press_held", key_held, 1'b1);
      chk("press_kr", kr, 4'hB);
      step(20);
      chk("press_once", n_pulse - p0, 1);
      chk("press_frozen", kr, 4'hB);
      key_on = 1'b0;
      step(8);
      chk("rel_early", key_held, 1'b1);
      i = 0;
      while (key_held && i < 10) begin step(1); i++; end
      chk("rel_drop", key_held, 1'b0);
      chk("rel_window", (i >= 3 && i <= 6), 1'b1);
      chk("rel_kr", kr, 4'h7);
      chk("rel_code", key_code, 4'd9);

      wait_row(4'h7);
      key_row = 2'd3; key_col = 2'd0; key_on = 1'b1;
      p0 = n_pulse;
      step(8);
      chk("bnc_frozen", kr, 4'h7);
      key_on = 1'b0;
      step(3);
      chk("bnc_still", kr, 4'h7);
      step(1);
      chk("bnc_resume", kr, 4'hE);
      chk("bnc_pulses", n_pulse - p0, 0);
      chk("bnc_held", key_held, 1'b0);

      force_kc = 4'h9; force_on = 1'b1;
      p0 = n_pulse;
      step(40);
      chk("ghost_pulses", n_pulse - p0, 0);
      chk("ghost_held", key_held, 1'b0);
      prev = kr;
      step(4);
      chk("ghost_adv", kr != prev, 1'b1);
      force_on = 1'b0;

      wait_row(4'hD);
      key_row = 2'd1; key_col = 2'd1; key_on = 1'b1;
      p0 = n_pulse;
      step(8);
      rst_n = 1'b0;
      #1;
      chk("arst_kr", kr, 4'hE);
      chk("arst_valid", key_valid, 1'b0);
      chk("arst_held", key_held, 1'b0);
      chk("arst_code", key_code, 4'h0);
      key_on = 1'b0;
      step(3);
      @(negedge clk) rst_n = 1'b1;
      step(3);
      chk("arst_row0", kr, 4'hE);
      step(1);
      chk("arst_row1", kr, 4'hD);
      chk("arst_pulses", n_pulse - p0, 0);

      key_row = 2'd1; key_col = 2'd1; key_on = 1'b1;
      p0 = n_pulse;
      wait_pulse("hold_valid");
      chk("hold_first_code", key_code, 4'd5);
      step(120);
      key_on = 1'b0;
      step(20);
      chk("hold_released", key_held, 1'b0);
`ifdef KEYPAD_REPEAT_EN
      chk("rep_count", n_pulse - p0, 7);
      for (int k = p0 + 1; k < n_pulse && k < p0 + 7; k++) begin
         chk("rep_gap", pulse_cyc[k] - pulse_cyc[k-1], (k == p0 + 1) ? 32 : 16);
         chk("rep_code", pulse_code[k], 4'd5);
      end
`else
      chk("hold_once", n_pulse - p0, 1);
      chk("hold_code", key_code, 4'd5);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles per row dwell; SHALL be at least 4.
REQ-002 Parameter DEBOUNCE_CNT, default 8: consecutive matching samples needed for press and release; SHALL be at least 1.
REQ-003 Parameter REPEAT_DELAY, default 250: ticks held before the first auto-repeat; used only under KEYPAD_REPEAT_EN.
REQ-004 Parameter REPEAT_RATE, default 50: ticks between auto-repeats; used only under KEYPAD_REPEAT_EN.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port kc, input, 4: column sense, active-low, asynchronous to clk.
REQ-008 Port kr, output, 4: row drive, one-cold (exactly one bit low).
REQ-009 Port key_valid, output, 1: one-cycle pulse per accepted key event.
REQ-010 Port key_code, output, 4: code of the last accepted key; held stable between events.
REQ-011 Port key_held, output, 1: high while an accepted key remains pressed.

Function
REQ-012 kc SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 A tick SHALL be a one-cycle internal strobe every SCAN_DIV cycles, counted from reset release; sampling occurs only on ticks.
REQ-014 Row order SHALL be 1110, 1101, 1011, 0111, then wrap to 1110.
REQ-015 Code mapping SHALL be code = 4*row_index + col_index; row 1110 = index 0 ... 0111 = index 3; column 1110 = index 0 ... 0111 = index 3.
REQ-016 A sample SHALL be a valid press only if synchronized kc has exactly one zero; 1111 or two or more zeros SHALL count as no press (ghost rejection).
REQ-017 The FSM SHALL have the states SCAN, DEBOUNCE and HELD.
REQ-018 SCAN: on a tick with no press, kr SHALL advance to the next row; on a valid press, the candidate code is latched, kr frozen, count=1, next state DEBOUNCE (DEBOUNCE_CNT=1 goes directly to acceptance).
REQ-019 DEBOUNCE: each tick with the same code SHALL increment count; a different code or no press SHALL clear count, advance kr and return to SCAN with no output.
REQ-020 Acceptance: when count reaches DEBOUNCE_CNT, key_code SHALL be updated and key_valid pulsed in the cycle after that tick; key_held SHALL rise in the same cycle; next state HELD.
REQ-021 HELD: kr SHALL stay frozen; each tick without the accepted key SHALL increment a release count and any tick with it SHALL clear that count; at DEBOUNCE_CNT, key_held SHALL drop, kr advance and the state return to SCAN.
REQ-022 Without repeat, exactly one key_valid SHALL occur per accepted press, however long it is held.
REQ-023 Counters SHALL be sized by $clog2 of their terminal value and SHALL saturate; they SHALL never wrap.

Reset
REQ-024 While rst_n is low: kr=1110, key_code=0, key_valid=0, key_held=0, state SCAN, and all counters and synchronizer flops cleared.
REQ-025 Reset asserted mid-DEBOUNCE or in HELD SHALL abort immediately with no key_valid pulse; scanning SHALL restart from row 1110 after release.

Configuration
REQ-026 With KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DELAY ticks, key_valid SHALL pulse again with the same key_code, then every REPEAT_RATE ticks until release begins; any missed sample (release count nonzero) SHALL restart the REPEAT_DELAY count.
REQ-027 Without KEYPAD_REPEAT_EN: no repeat logic is built, REPEAT_DELAY and REPEAT_RATE are ignored, and REQ-022 applies.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DELAY=8, REPEAT_RATE=4)
REQ-028 Idle: kc=1111 for 40 cycles -> kr steps 1110,1101,1011,0111,1110 every 4 cycles; key_valid never asserted.
REQ-029 Press: kc=1101 held whenever kr=1011 -> one key_valid with key_code=9; key_held=1; key_held falls 3 ticks after kc returns to 1111.
REQ-030 Bounce: kc=1110 on row 0111 for 2 ticks, then 1111 -> no key_valid; kr resumes advancing.
REQ-031 Ghost: kc=1001 on row 1110 for 10 ticks -> no key_valid; key_held stays 0.
REQ-032 Reset: rst_n pulled low after the 2nd matching tick of a press -> outputs at reset values at once; kr=1110; no pulse.
REQ-033 Repeat (macro defined): key 5 held 30 ticks -> key_valid at acceptance, then 8 ticks later, then every 4 ticks; key_code=5 on every pulse.
